// File: rtl/bram_axis_line_reader.sv
// Streams BRAM lines start_index..bound_index (inclusive, wrapping) word by word onto an
// AXI-Stream master, MSB slice first, prefetching the next line while the current one drains.
module bram_axis_line_reader #(
    parameter int BRAM_ADDR_LENGTH   = 12,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int WORD_WIDTH         = 8,
    parameter int CNT_BITS           = 6
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [BRAM_ADDR_LENGTH-1:0]                start_index,
    input  logic [BRAM_ADDR_LENGTH-1:0]                bound_index,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       bram_en,
    output logic [BRAM_ADDR_LENGTH-1:0]                bram_index,
    input  logic [BRAM_WIDTH_IN_WORD*WORD_WIDTH-1:0]   bram_rdata,
    output logic [WORD_WIDTH-1:0]                      m_axis_tdata,
    output logic                                       m_axis_tvalid,
    input  logic                                       m_axis_tready,
    output logic                                       m_axis_tlast,
    output logic [CNT_BITS-1:0]                        cnt
);
    localparam int LINE_W = BRAM_WIDTH_IN_WORD * WORD_WIDTH;
    localparam logic [CNT_BITS-1:0]         LAST_CNT = CNT_BITS'(BRAM_WIDTH_IN_WORD - 1);
    localparam logic [CNT_BITS-1:0]         CNT_ONE  = CNT_BITS'(1);
    localparam logic [BRAM_ADDR_LENGTH-1:0] IDX_ONE  = BRAM_ADDR_LENGTH'(1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_STREAM = 2'd2} state_t;

    state_t                      state_r, state_s;
    logic [BRAM_ADDR_LENGTH-1:0] bound_r, bound_s, bram_index_r, bram_index_s, idx_next_s;
    logic                        bram_en_r, bram_en_s, rvalid_r, rvalid_s;
    logic                        issued_bound_r, issued_bound_s;
    logic [LINE_W-1:0]           cur_buf_r, cur_buf_s, pre_buf_r, pre_buf_s;
    logic                        cur_full_r, cur_full_s, cur_last_r, cur_last_s;
    logic                        pre_full_r, pre_full_s, pre_last_r, pre_last_s;
    logic [CNT_BITS-1:0]         cnt_r, cnt_s;
    logic                        busy_r, busy_s, done_r, done_s, tlast_r, tlast_s;
    logic                        hs_s, rd_used_s;

    // CUR is a shift register: the word on the bus is always its top slice.
    assign busy          = busy_r;
    assign done          = done_r;
    assign bram_en       = bram_en_r;
    assign bram_index    = bram_index_r;
    assign m_axis_tdata  = cur_buf_r[LINE_W-1 -: WORD_WIDTH];
    assign m_axis_tvalid = cur_full_r;
    assign m_axis_tlast  = tlast_r;
    assign cnt           = cnt_r;

    // Next-state, buffer movement and read-issue decisions.
    always_comb begin
        state_s        = state_r;
        bound_s        = bound_r;
        bram_index_s   = bram_index_r;
        bram_en_s      = 1'b0;
        rvalid_s       = bram_en_r;
        issued_bound_s = issued_bound_r;
        cur_buf_s      = cur_buf_r;
        cur_full_s     = cur_full_r;
        cur_last_s     = cur_last_r;
        pre_buf_s      = pre_buf_r;
        pre_full_s     = pre_full_r;
        pre_last_s     = pre_last_r;
        cnt_s          = cnt_r;
        busy_s         = busy_r;
        done_s         = 1'b0;
        rd_used_s      = 1'b0;
        hs_s           = cur_full_r & m_axis_tready;
        idx_next_s     = bram_index_r + IDX_ONE;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s        = ST_FETCH;
                    busy_s         = 1'b1;
                    bound_s        = bound_index;
                    bram_index_s   = start_index;
                    bram_en_s      = 1'b1;
                    issued_bound_s = (start_index == bound_index);
                    cur_full_s     = 1'b0;
                    pre_full_s     = 1'b0;
                    cnt_s          = '0;
                end else begin
                    rvalid_s = 1'b0;
                end
            end
            ST_FETCH, ST_STREAM: begin
                if (abort) begin
                    state_s    = ST_IDLE;
                    busy_s     = 1'b0;
                    rvalid_s   = 1'b0;
                    cur_full_s = 1'b0;
                    pre_full_s = 1'b0;
                    cnt_s      = '0;
                end else begin
                    if (hs_s) begin
                        if (cnt_r == LAST_CNT) begin
                            cnt_s = '0;
                            if (cur_last_r) begin
                                state_s    = ST_IDLE;
                                busy_s     = 1'b0;
                                done_s     = 1'b1;
                                cur_full_s = 1'b0;
                            end else if (pre_full_r) begin
                                cur_buf_s  = pre_buf_r;
                                cur_last_s = pre_last_r;
                                pre_full_s = 1'b0;
                            end else if (rvalid_r) begin
                                // Data arriving exactly at the line switch bypasses PRE.
                                cur_buf_s  = bram_rdata;
                                cur_last_s = issued_bound_r;
                                rd_used_s  = 1'b1;
                            end else begin
                                cur_full_s = 1'b0;
                            end
                        end else begin
                            cnt_s     = cnt_r + CNT_ONE;
                            cur_buf_s = cur_buf_r << WORD_WIDTH;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                    if (rvalid_r && !rd_used_s) begin
                        if (!cur_full_r) begin
                            cur_buf_s  = bram_rdata;
                            cur_full_s = 1'b1;
                            cur_last_s = issued_bound_r;
                            state_s    = ST_STREAM;
                        end else begin
                            pre_buf_s  = bram_rdata;
                            pre_full_s = 1'b1;
                            pre_last_s = issued_bound_r;
                        end
                    end else begin
                        rd_used_s = rd_used_s;
                    end
                    if (!issued_bound_r && !pre_full_r && !bram_en_r && !rvalid_r && (state_s != ST_IDLE)) begin
                        bram_en_s      = 1'b1;
                        bram_index_s   = idx_next_s;
                        issued_bound_s = (idx_next_s == bound_r);
                    end else begin
                        bram_en_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s    = ST_IDLE;
                busy_s     = 1'b0;
                rvalid_s   = 1'b0;
                cur_full_s = 1'b0;
                pre_full_s = 1'b0;
                cnt_s      = '0;
            end
        endcase
        tlast_s = cur_full_s && (cnt_s == LAST_CNT) && cur_last_s;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            bound_r        <= '0;
            bram_index_r   <= '0;
            bram_en_r      <= 1'b0;
            rvalid_r       <= 1'b0;
            issued_bound_r <= 1'b0;
            cur_buf_r      <= '0;
            cur_full_r     <= 1'b0;
            cur_last_r     <= 1'b0;
            pre_buf_r      <= '0;
            pre_full_r     <= 1'b0;
            pre_last_r     <= 1'b0;
            cnt_r          <= '0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            tlast_r        <= 1'b0;
        end else begin
            state_r        <= state_s;
            bound_r        <= bound_s;
            bram_index_r   <= bram_index_s;
            bram_en_r      <= bram_en_s;
            rvalid_r       <= rvalid_s;
            issued_bound_r <= issued_bound_s;
            cur_buf_r      <= cur_buf_s;
            cur_full_r     <= cur_full_s;
            cur_last_r     <= cur_last_s;
            pre_buf_r      <= pre_buf_s;
            pre_full_r     <= pre_full_s;
            pre_last_r     <= pre_last_s;
            cnt_r          <= cnt_s;
            busy_r         <= busy_s;
            done_r         <= done_s;
            tlast_r        <= tlast_s;
        end
    end
endmodule
